// File: rtl/alu_mul_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier controller and its ALU.
package alu_mul_ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // Datapath width of the ripple ALU
  localparam int unsigned ALU_W = 6;

  // One RUN cycle per multiplier bit
  localparam int unsigned ITER_COUNT = 6;
  localparam int unsigned CNT_W      = $clog2(ITER_COUNT);

endpackage

// File: rtl/alu_mul_ctrl_alu.sv
// 6-bit ripple-carry ALU: AND, OR, ADD, SUB. Purely combinational.
module ALU_6_bit
  import alu_mul_ctrl_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic             cin,
  input  logic [3:0]       op,
  output logic [ALU_W-1:0] result,
  output logic             cout
);

  logic [ALU_W:0]   c;
  logic [ALU_W-1:0] bx;
  logic [ALU_W-1:0] sum;

  // Ripple adder; subtraction inverts b and forces the carry-in high
  always_comb begin
    bx   = (op == ALU_SUB) ? ~b : b;
    c    = '0;
    c[0] = (op == ALU_SUB) ? 1'b1 : cin;
    sum  = '0;
    for (int unsigned i = 0; i < ALU_W; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
  end

  // Result and carry-out selection by op code
  always_comb begin
    result = '0;
    cout   = 1'b0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD,
      ALU_SUB: begin
        result = sum;
        cout   = c[ALU_W];
      end
      default: begin
        result = '0;
        cout   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_mul_ctrl.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, one bit per cycle,
// using the shared ripple ALU as its only adder.
module alu_mul_ctrl
  import alu_mul_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER_COUNT - 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] alu_sum;
  logic             alu_cout;

  ALU_6_bit u_alu (
    .a      (acc),
    .b      (mcand),
    .cin    (1'b0),
    .op     (ALU_ADD),
    .result (alu_sum),
    .cout   (alu_cout)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (count == LAST_ITER) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state; product is the live {acc,q} register pair
  always_comb begin
    busy    = (state == RUN);
    done    = (state == DONE);
    product = {acc, q};
  end

  // Datapath: load on accepted start, one shift(-add) step per RUN cycle.
  // The {acc,q} pair shifts right as one register, the ALU carry-out
  // becoming the new acc MSB when the partial product is added.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      q     <= '0;
      mcand <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= a;
            q     <= b;
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (q[0]) begin
            acc <= {alu_cout, alu_sum[WIDTH-1:1]};
            q   <= {alu_sum[0], q[WIDTH-1:1]};
          end else begin
            acc <= {1'b0, acc[WIDTH-1:1]};
            q   <= {acc[0], q[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_ctrl.sv
// Scoreboard bench for alu_mul_ctrl: stimulus pushes expected product and
// acceptance edge; a negedge monitor checks busy/done/product every cycle.
module tb_alu_mul_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  a;
  logic [5:0]  b;
  logic        busy;
  logic        done;
  logic [11:0] product;

  alu_mul_ctrl #(.WIDTH(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] prod;
    int          acc_edge;
  } exp_t;

  exp_t        sb[$];
  int          edge_cnt  = 0;
  int          n_checks  = 0;
  int          n_errors  = 0;
  bit          mon_en    = 1'b0;
  logic [11:0] last_prod = '0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got 0x%0h expected 0x%0h", name, edge_cnt, act, exp);
    end
  endtask

  // Monitor: derive expected busy/done from the front entry's acceptance edge
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_busy;
      bit exp_done;
      exp_t e;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      if (sb.size() > 0) begin
        int d;
        e = sb[0];
        d = edge_cnt - e.acc_edge;
        exp_busy = (d >= 0) && (d <= 5);
        exp_done = (d == 6);
      end
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("busy_done_excl", 32'(busy & done), 32'd0);
      if (exp_done) begin
        chk("product", 32'(product), 32'(e.prod));
        last_prod = e.prod;
        void'(sb.pop_front());
      end else if (!exp_busy) begin
        chk("product_hold", 32'(product), 32'(last_prod));
      end
    end
  end

  // Called at posedge+1: start is sampled at the next edge; afterwards a/b are
  // scrambled and the task returns one edge after the DONE cycle.
  task automatic run_op(input logic [5:0] x, input logic [5:0] y);
    exp_t e;
    start = 1'b1;
    a = x;
    b = y;
    e.prod = 12'(int'(x) * int'(y));
    e.acc_edge = edge_cnt + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = 6'($urandom);
    b = 6'($urandom);
    repeat (7) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    exp_t e;
    int   n0;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // First start at the first edge with reset low
    run_op(6'd5, 6'd3);
    run_op(6'h3F, 6'h3F);
    run_op(6'd0, 6'h2A);
    run_op(6'h20, 6'h02);

    // 9*9 with a 7*7 start pulse during RUN cycle 3 (must be ignored)
    start = 1'b1;
    a = 6'd9;
    b = 6'd9;
    e.prod = 12'h051;
    e.acc_edge = edge_cnt + 1;
    n0 = e.acc_edge;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    idle(2);
    start = 1'b1;
    a = 6'd7;
    b = 6'd7;
    idle(1);
    start = 1'b0;
    while (edge_cnt < n0 + 7) idle(1);

    // Reset during RUN cycle 4: abandon, then a fresh multiply
    start = 1'b1;
    a = 6'd13;
    b = 6'd11;
    e.prod = 12'(13 * 11);
    e.acc_edge = edge_cnt + 1;
    sb.push_back(e);
    idle(1);
    start = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(1);
    sb.delete();
    last_prod = '0;
    reset = 1'b0;
    idle(1);
    run_op(6'd6, 6'd7);

    // Start held high: three results 8 cycles apart
    n0 = edge_cnt + 1;
    start = 1'b1;
    a = 6'd2;
    b = 6'd3;
    for (int i = 0; i < 3; i++) begin
      e.prod = 12'h006;
      e.acc_edge = n0 + 8 * i;
      sb.push_back(e);
    end
    idle(17);
    start = 1'b0;
    idle(7);

    // Randomized operands and gaps
    for (int i = 0; i < 25; i++) begin
      run_op(6'($urandom), 6'($urandom));
      idle(int'($urandom_range(0, 3)));
    end

    idle(4);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
